// File: rtl/serial_wb_pkg.sv
// Shared constants, register map and parser state encoding for the serial
// command bridge.
package serial_wb_pkg;

    localparam logic [7:0]  CMD_WRITE = 8'hA2;
    localparam logic [7:0]  CMD_READ  = 8'hA1;

    localparam logic [31:0] ADDR_ID   = 32'h0000_0000;
    localparam logic [31:0] ADDR_LED  = 32'h0000_0004;
    localparam logic [31:0] ADDR_SLED = 32'h0000_0200;
    localparam logic [31:0] ID_VALUE  = 32'h4D49_4431;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR0,
        ST_ADDR1,
        ST_ADDR2,
        ST_ADDR3,
        ST_CNT0,
        ST_CNT1,
        ST_WDATA,
        ST_BUS,
        ST_RDATA,
        ST_ACK
    } state_e;

    // Little-endian byte lane select: idx 0 returns bits 7:0.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/led_shift_out.sv
// Serial LED shifter: loads 32 bits and clocks them out MSB first; data moves
// on the falling edge of led_clk_o so it is stable around each rising edge.
module led_shift_out #(
    parameter int LED_CLK_DIV = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        load_i,
    input  logic [31:0] data_i,
    output logic        busy_o,
    output logic        led_clk_o,
    output logic        led_data_o
);

    localparam logic [15:0] DIV_LAST = 16'(LED_CLK_DIV - 1);

    logic [31:0] shreg_q;
    logic [4:0]  bit_q;
    logic [15:0] div_q;
    logic        busy_q;
    logic        clk_q;
    logic        data_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            shreg_q <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            busy_q  <= 1'b0;
            clk_q   <= 1'b0;
            data_q  <= 1'b0;
        end else if (!busy_q) begin
            if (load_i) begin
                shreg_q <= data_i;
                data_q  <= data_i[31];
                busy_q  <= 1'b1;
                bit_q   <= '0;
                div_q   <= '0;
                clk_q   <= 1'b0;
            end
        end else if (div_q != DIV_LAST) begin
            div_q <= div_q + 16'd1;
        end else begin
            div_q <= '0;
            if (!clk_q) begin
                clk_q <= 1'b1;
            end else begin
                // Falling edge: either finish or present the next bit.
                clk_q <= 1'b0;
                if (bit_q == 5'd31) begin
                    busy_q <= 1'b0;
                    data_q <= 1'b0;
                end else begin
                    bit_q   <= bit_q + 5'd1;
                    shreg_q <= {shreg_q[30:0], 1'b0};
                    data_q  <= shreg_q[30];
                end
            end
        end
    end

    assign busy_o     = busy_q;
    assign led_clk_o  = clk_q;
    assign led_data_o = data_q;

endmodule

// File: rtl/serial_wb_middle.sv
// Byte-stream command bridge: parses framed read/write commands, performs
// 32-bit register accesses and streams back the ack and read data.
module serial_wb_middle
    import serial_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int LED_CLK_DIV    = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic [7:0] o_led,
    output logic       o_led_clk,
    output logic       o_led_data,
    output logic       o_debug_0
);

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    // Both streams use plain AXI-Stream rules: a byte moves on a cycle where
    // valid and ready are both high; valid never waits on ready.
    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] cnt_q, cnt_d;
    logic        is_read_q, is_read_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  bidx_q, bidx_d;
    logic [31:0] rword_q, rword_d;
    logic [31:0] to_q, to_d;
    logic        bus_ack_q;
    logic [31:0] bus_rdata_q;
    logic [7:0]  led_q;

    logic        in_fire, out_fire, frame_wait, bus_stb, sled_busy;
    logic [31:0] rd_mux;

    assign in_fire  = s_axis_tvalid && s_axis_tready;
    assign out_fire = m_axis_tvalid && m_axis_tready;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            is_read_q <= 1'b0;
            word_q    <= '0;
            bidx_q    <= '0;
            rword_q   <= '0;
            to_q      <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            is_read_q <= is_read_d;
            word_q    <= word_d;
            bidx_q    <= bidx_d;
            rword_q   <= rword_d;
            to_q      <= to_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        is_read_d  = is_read_q;
        word_d     = word_q;
        bidx_d     = bidx_q;
        rword_d    = rword_q;
        to_d       = '0;
        frame_wait = (state_q != ST_IDLE) && (state_q != ST_BUS) &&
                     (state_q != ST_RDATA) && (state_q != ST_ACK);
        if (frame_wait && !in_fire) to_d = to_q + 32'd1;

        case (state_q)
            ST_IDLE: begin
                if (in_fire && (s_axis_tdata == CMD_WRITE || s_axis_tdata == CMD_READ)) begin
                    is_read_d = (s_axis_tdata == CMD_READ);
                    state_d   = ST_ADDR0;
                end
            end
            ST_ADDR0, ST_ADDR1, ST_ADDR2, ST_ADDR3: begin
                if (in_fire) begin
                    addr_d  = {addr_q[23:0], s_axis_tdata};
                    state_d = state_e'(state_q + 4'd1);
                end
            end
            ST_CNT0: begin
                if (in_fire) begin
                    cnt_d   = {cnt_q[7:0], s_axis_tdata};
                    state_d = ST_CNT1;
                end
            end
            ST_CNT1: begin
                if (in_fire) begin
                    cnt_d  = {cnt_q[7:0], s_axis_tdata};
                    bidx_d = '0;
                    if (is_read_q || cnt_d == 16'd0) state_d = ST_ACK;
                    else                              state_d = ST_WDATA;
                end
            end
            ST_WDATA: begin
                if (in_fire) begin
                    word_d[{bidx_q, 3'b000} +: 8] = s_axis_tdata;
                    bidx_d = bidx_q + 2'd1;
                    cnt_d  = cnt_q - 16'd1;
                    // A short trailing word never reaches the bus.
                    if (bidx_q == 2'd3)      state_d = ST_BUS;
                    else if (cnt_q == 16'd1) state_d = ST_ACK;
                end
            end
            ST_BUS: begin
                if (bus_ack_q) begin
                    addr_d = addr_q + 32'd4;
                    if (is_read_q) begin
                        rword_d = bus_rdata_q;
                        cnt_d   = cnt_q - 16'd4;
                        bidx_d  = '0;
                        state_d = ST_RDATA;
                    end else if (cnt_q == 16'd0) begin
                        state_d = ST_ACK;
                    end else begin
                        state_d = ST_WDATA;
                    end
                end
            end
            ST_RDATA: begin
                if (out_fire) begin
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) state_d = (cnt_q >= 16'd4) ? ST_BUS : ST_IDLE;
                end
            end
            ST_ACK: begin
                if (out_fire) state_d = (is_read_q && cnt_q >= 16'd4) ? ST_BUS : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (frame_wait && !in_fire && to_q == TO_LAST) state_d = ST_IDLE;
    end

    always_comb begin
        s_axis_tready = !((state_q == ST_BUS) || (state_q == ST_RDATA) || (state_q == ST_ACK));
        m_axis_tvalid = (state_q == ST_ACK) || (state_q == ST_RDATA);
        m_axis_tdata  = 8'h00;
        if (state_q == ST_ACK)        m_axis_tdata = is_read_q ? CMD_READ : CMD_WRITE;
        else if (state_q == ST_RDATA) m_axis_tdata = word_byte(rword_q, bidx_q);
        o_debug_0 = (state_q != ST_IDLE);
        bus_stb   = (state_q == ST_BUS) && !bus_ack_q;
    end

    always_comb begin
        case (addr_q)
            ADDR_ID:   rd_mux = ID_VALUE;
            ADDR_LED:  rd_mux = {24'h0, led_q};
            ADDR_SLED: rd_mux = {31'h0, sled_busy};
            default:   rd_mux = '0;
        endcase
    end

    // Register bank: the request cycle performs the access, ack follows.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            bus_ack_q   <= 1'b0;
            bus_rdata_q <= '0;
            led_q       <= '0;
        end else begin
            bus_ack_q <= bus_stb;
            if (bus_stb) begin
                bus_rdata_q <= rd_mux;
                if (!is_read_q && addr_q == ADDR_LED) led_q <= word_q[7:0];
            end
        end
    end

    led_shift_out #(
        .LED_CLK_DIV(LED_CLK_DIV)
    ) u_led_shift (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .load_i     (bus_stb && !is_read_q && addr_q == ADDR_SLED),
        .data_i     (word_q),
        .busy_o     (sled_busy),
        .led_clk_o  (o_led_clk),
        .led_data_o (o_led_data)
    );

    assign o_led = led_q;

endmodule

// File: tb/tb_serial_wb_middle.sv
// Directed bench for serial_wb_middle: a table of command frames plus
// hand-written sequences for shifting, timeout, back-pressure and reset.
module tb_serial_wb_middle;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_tdata = 8'h00;
    logic       s_tvalid = 1'b0;
    logic       s_tready;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready = 1'b1;
    logic [7:0] led;
    logic       led_clk, led_data, dbg;

    int n_cmp = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] addr;
        logic [15:0] cnt;
        logic [31:0] wdata;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [7:0]  led;
    } vec_t;

    vec_t vecs[12];

    serial_wb_middle #(
        .TIMEOUT_CYCLES(100),
        .LED_CLK_DIV   (4)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst_n),
        .s_axis_tdata (s_tdata),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .m_axis_tdata (m_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .o_led        (led),
        .o_led_clk    (led_clk),
        .o_led_data   (led_data),
        .o_debug_0    (dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running, required finished");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every outbound transfer must match the head of exp_q.
    always @(negedge clk) begin
        if (rst_n && m_tvalid && m_tready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL out_extra: got %02h, required no byte", m_tdata);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (m_tdata !== e) begin
                    n_fail++;
                    $display("FAIL out_byte: got %02h, required %02h", m_tdata, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, required %08h", name, got, exp);
        end
    endtask

    task automatic gap();
        repeat (3) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, output int stalls);
        stalls = 0;
        @(negedge clk);
        s_tdata  = b;
        s_tvalid = 1'b1;
        while (!s_tready && stalls < 64) begin
            @(negedge clk);
            stalls++;
        end
        if (!s_tready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL in_wait: tready %0b after %0d cycles, required 1", s_tready, stalls);
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tdata  = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [15:0] cnt,
                              input logic [31:0] wdata, output int stalls, output logic dbg_mid);
        int s;
        stalls = 0;
        send_byte(cmd, s);
        stalls += s;
        dbg_mid = dbg;
        gap();
        for (int i = 0; i < 4; i++) begin
            send_byte(addr[31-8*i -: 8], s);
            stalls += s;
            gap();
        end
        send_byte(cnt[15:8], s);
        stalls += s;
        gap();
        send_byte(cnt[7:0], s);
        stalls += s;
        gap();
        if (cmd == 8'hA2) begin
            for (int i = 0; i < int'(cnt); i++) begin
                send_byte(wdata[8*(i%4) +: 8], s);
                stalls += s;
                gap();
            end
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d bytes still expected, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int stalls, pulses, extra;
        logic dbg_mid, prev;
        logic [31:0] bits;
        logic [7:0] held;

        vecs[0]  = '{8'hA2, 32'h0000_0004, 16'd4, 32'h4433_2211, 32'h0, 32'h0, 8'h11};
        vecs[1]  = '{8'hA1, 32'h0000_0000, 16'd8, 32'h0, 32'h4D49_4431, 32'h0000_0011, 8'h11};
        vecs[2]  = '{8'hA2, 32'h0000_0004, 16'd6, 32'h0000_00C3, 32'h0, 32'h0, 8'hC3};
        vecs[3]  = '{8'hA1, 32'h0000_0004, 16'd5, 32'h0, 32'h0000_00C3, 32'h0, 8'hC3};
        vecs[4]  = '{8'hA2, 32'h0000_0004, 16'd0, 32'h0000_00AA, 32'h0, 32'h0, 8'hC3};
        vecs[5]  = '{8'hA1, 32'h0000_0000, 16'd0, 32'h0, 32'h0, 32'h0, 8'hC3};
        vecs[6]  = '{8'hA1, 32'h0000_0100, 16'd4, 32'h0, 32'h0, 32'h0, 8'hC3};
        vecs[7]  = '{8'hA2, 32'h0000_0100, 16'd4, 32'h0000_00EE, 32'h0, 32'h0, 8'hC3};
        vecs[8]  = '{8'hA2, 32'h0000_0000, 16'd4, 32'hFFFF_FFFF, 32'h0, 32'h0, 8'hC3};
        vecs[9]  = '{8'hA1, 32'h0000_0000, 16'd4, 32'h0, 32'h4D49_4431, 32'h0, 8'hC3};
        vecs[10] = '{8'hA2, 32'h0000_0004, 16'd8, 32'h0000_005A, 32'h0, 32'h0, 8'h5A};
        vecs[11] = '{8'hA1, 32'h0000_0200, 16'd4, 32'h0, 32'h0, 32'h0, 8'h5A};

        // Clock / reset
        repeat (3) @(negedge clk);
        check("rst_tready", {31'h0, s_tready}, 32'h1);
        check("rst_mvalid", {31'h0, m_tvalid}, 32'h0);
        check("rst_mdata", {24'h0, m_tdata}, 32'h0);
        check("rst_led", {24'h0, led}, 32'h0);
        check("rst_ledclk", {30'h0, led_clk, led_data}, 32'h0);
        check("rst_debug", {31'h0, dbg}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven frames
        for (int v = 0; v < 12; v++) begin
            exp_q.push_back(vecs[v].cmd);
            if (vecs[v].cmd == 8'hA1) begin
                for (int w = 0; w < int'(vecs[v].cnt) / 4; w++)
                    push_word(w == 0 ? vecs[v].rd0 : vecs[v].rd1);
            end
            send_frame(vecs[v].cmd, vecs[v].addr, vecs[v].cnt, vecs[v].wdata, stalls, dbg_mid);
            wait_drain();
            check($sformatf("v%0d_led", v), {24'h0, led}, {24'h0, vecs[v].led});
            check($sformatf("v%0d_stalls", v), stalls, 0);
            check($sformatf("v%0d_dbg_mid", v), {31'h0, dbg_mid}, 32'h1);
            check($sformatf("v%0d_dbg_end", v), {31'h0, dbg}, 32'h0);
        end

        // Unknown command byte in IDLE is dropped
        send_byte(8'h55, stalls);
        repeat (3) @(negedge clk);
        check("bad_cmd_debug", {31'h0, dbg}, 32'h0);
        exp_q.push_back(8'hA2);
        send_frame(8'hA2, 32'h4, 16'd4, 32'h0000_0077, stalls, dbg_mid);
        wait_drain();
        check("bad_cmd_led", {24'h0, led}, 32'h77);

        // Serial LED shift-out, write-while-busy ignored, busy readback
        bits = '0;
        pulses = 0;
        fork
            begin
                prev = 1'b0;
                for (int c = 0; c < 1200 && pulses < 32; c++) begin
                    @(negedge clk);
                    if (led_clk && !prev) begin
                        bits = {bits[30:0], led_data};
                        pulses++;
                    end
                    prev = led_clk;
                end
            end
            begin
                exp_q.push_back(8'hA2);
                send_frame(8'hA2, 32'h200, 16'd4, 32'h4433_2211, stalls, dbg_mid);
                wait_drain();
                exp_q.push_back(8'hA2);
                send_frame(8'hA2, 32'h200, 16'd4, 32'h1234_5678, stalls, dbg_mid);
                wait_drain();
                exp_q.push_back(8'hA1);
                push_word(32'h1);
                send_frame(8'hA1, 32'h200, 16'd4, 32'h0, stalls, dbg_mid);
                wait_drain();
            end
        join
        check("shift_pulses", pulses, 32);
        check("shift_bits", bits, 32'h4433_2211);
        extra = 0;
        prev = led_clk;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (led_clk && !prev) extra++;
            prev = led_clk;
        end
        check("shift_extra", extra, 0);
        check("shift_idle_clk", {31'h0, led_clk}, 32'h0);
        exp_q.push_back(8'hA1);
        push_word(32'h0);
        send_frame(8'hA1, 32'h200, 16'd4, 32'h0, stalls, dbg_mid);
        wait_drain();

        // Mid-frame timeout after the address bytes
        send_byte(8'hA2, stalls);
        for (int i = 0; i < 4; i++) begin
            gap();
            send_byte(i == 3 ? 8'h04 : 8'h00, stalls);
        end
        repeat (50) @(negedge clk);
        check("to_debug_mid", {31'h0, dbg}, 32'h1);
        repeat (70) @(negedge clk);
        check("to_debug_end", {31'h0, dbg}, 32'h0);
        exp_q.push_back(8'hA2);
        send_frame(8'hA2, 32'h4, 16'd4, 32'h0000_0099, stalls, dbg_mid);
        wait_drain();
        check("to_next_led", {24'h0, led}, 32'h99);

        // Back-pressure: ack held stable until ready
        @(posedge clk);
        #1 m_tready = 1'b0;
        exp_q.push_back(8'hA1);
        push_word(32'h4D49_4431);
        send_frame(8'hA1, 32'h0, 16'd4, 32'h0, stalls, dbg_mid);
        repeat (6) @(negedge clk);
        check("bp_valid", {31'h0, m_tvalid}, 32'h1);
        held = m_tdata;
        check("bp_data", {24'h0, held}, 32'hA1);
        repeat (5) @(negedge clk);
        check("bp_data_held", {24'h0, m_tdata}, 32'hA1);
        check("bp_tready", {31'h0, s_tready}, 32'h0);
        @(posedge clk);
        #1 m_tready = 1'b1;
        wait_drain();

        // Reset mid-payload while the shifter is running
        exp_q.push_back(8'hA2);
        send_frame(8'hA2, 32'h200, 16'd4, 32'hFFFF_FFFF, stalls, dbg_mid);
        wait_drain();
        send_byte(8'hA2, stalls);
        for (int i = 0; i < 6; i++) begin
            gap();
            send_byte(i == 3 ? 8'h04 : (i == 5 ? 8'h04 : 8'h00), stalls);
        end
        gap();
        send_byte(8'h11, stalls);
        gap();
        send_byte(8'h22, stalls);
        @(negedge clk);
        check("pre_rst_debug", {31'h0, dbg}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tready", {31'h0, s_tready}, 32'h1);
        check("mid_rst_mvalid", {31'h0, m_tvalid}, 32'h0);
        check("mid_rst_mdata", {24'h0, m_tdata}, 32'h0);
        check("mid_rst_led", {24'h0, led}, 32'h0);
        check("mid_rst_ledclk", {31'h0, led_clk}, 32'h0);
        check("mid_rst_leddata", {31'h0, led_data}, 32'h0);
        check("mid_rst_debug", {31'h0, dbg}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        exp_q.push_back(8'hA1);
        push_word(32'h0);
        send_frame(8'hA1, 32'h4, 16'd4, 32'h0, stalls, dbg_mid);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_wb_middle.md
# serial_wb_middle

Byte-stream command bridge between a UART-facing AXI-Stream byte pipe and an internal Wishbone-style register bus. It parses framed read/write commands from the inbound stream, performs 32-bit register accesses, and returns acknowledge and read data on the outbound stream. On-chip registers drive a parallel LED port, a serial LED shifter, and a debug pin. It sits between the UART receiver/transmitter and the board I/O.

## Interface
- `TIMEOUT_CYCLES`, default 1_000_000: idle cycles mid-frame before the parser aborts to IDLE.
- `LED_CLK_DIV`, default 4: `i_clk` cycles per half period of `o_led_clk`.
- `i_clk` in 1: single clock, all logic on rising edge.
- `i_rst` in 1: asynchronous, active-low reset (0 = reset).
- `s_axis_tdata` in 8: inbound command byte.
- `s_axis_tvalid` in 1: inbound byte valid.
- `s_axis_tready` out 1: bridge accepts a byte; transfer when valid&&ready.
- `m_axis_tdata` out 8: outbound response byte.
- `m_axis_tvalid` out 1: outbound byte valid; held with stable data until ready.
- `m_axis_tready` in 1: downstream accepts.
- `o_led` out 8: parallel LED register.
- `o_led_clk` out 1: serial LED shift clock, idles low.
- `o_led_data` out 1: serial LED data, MSB first.
- `o_debug_0` out 1: high while a frame is in progress (parser not IDLE).

## Operation
- Frame: CMD(1) ADDR(4, big-endian) COUNT(2, big-endian, bytes) then payload.
- CMD 0xA2 write: COUNT payload bytes follow, little-endian within each 32-bit word (first byte = bits 7:0). Each complete word is written to ADDR, ADDR+4, …. After the last byte, emit one ack byte 0xA2.
- CMD 0xA1 read: no payload. Emit ack 0xA1, then COUNT/4 words, each little-endian, from ADDR, ADDR+4, ….
- Other CMD values: byte dropped, stay in IDLE.
- COUNT not a multiple of 4: trailing bytes of a write are consumed and discarded; a read returns floor(COUNT/4) words. COUNT=0: no bus access, ack still sent.
- States: IDLE, ADDR0–3, CNT0–1, WDATA, BUS, RDATA, ACK.
- Register map (word addresses; unmapped: writes ignored, reads 0):
  - 0x0000_0000: ID, read-only 0x4D49_4431.
  - 0x0000_0004: LED; bits 7:0 drive `o_led`, read back.
  - 0x0000_0200: serial LED; a write loads 32 bits and starts shift-out. Read returns {31'b0, busy}. A write while busy is ignored.
- Serial shift: 32 bits MSB first. Data changes while `o_led_clk` is low and is sampled on its rising edge. Each half period is LED_CLK_DIV cycles. Clock returns low at the end.
- Timeout: no inbound byte for TIMEOUT_CYCLES while in a frame → IDLE, no ack, partial word discarded.

## Timing
- Reset values: `s_axis_tready`=1, `m_axis_tvalid`=0, `m_axis_tdata`=0, `o_led`=0, `o_led_clk`=0, `o_led_data`=0, `o_debug_0`=0. All registers are cleared.
- `s_axis_tready` is low only in BUS, RDATA and ACK.
- Internal bus access takes 2 cycles: request, then ack. After the 4th byte of a word, `s_axis_tready` returns high within 3 cycles. A source sending one byte per 4 cycles is never stalled.
- Ack is presented the cycle after the last payload byte is committed. Read words are presented back-to-back, honouring `m_axis_tready`.
- Reset mid-frame or mid-shift aborts immediately to reset values.

## Structure
- Package `serial_wb_pkg`: CMD_WRITE=0xA2, CMD_READ=0xA1, register addresses, ID constant, parser state enum.
- Sub-module `led_shift_out`: serial LED shifter with load/busy interface, parameterised by LED_CLK_DIV.
- Top module: parser FSM, word assembler, register bank and response mux.

## Test plan
- Write 0xA2, addr 0x0000_0004, count 0x0004, bytes 11 22 33 44 (one byte per 4 cycles) → `o_led`=0x11, one 0xA2 byte out, `o_debug_0` high during the frame only.
- Write 0x4433_2211 to 0x0000_0200 → `o_led_data` shifts 0x44332211 MSB first over 32 `o_led_clk` pulses.
- Read 0xA1, addr 0x0000_0000, count 8 → out: A1, 31 44 49 4D, 11 00 00 00 (after the first test).
- Byte 0x55 in IDLE, then a valid write → 0x55 ignored, write succeeds.
- Stop a frame after the address bytes for TIMEOUT_CYCLES (override to 100) → back to IDLE, no output, next frame works.
- Assert `i_rst` (low) mid-payload and hold `m_axis_tready` low during a read → all outputs at reset values; read data held stable until ready.
